// File: rtl/atm_keypad_entry_if.sv
`default_nettype none
// ============================================================================
//  Module      : atm_keypad_entry_if
//  Description : Keypad strobes in, parallel controller inputs and status out
//                for the ATM keypad entry front end.
//  Revision    : 1.0 - initial release
// ============================================================================
interface atm_keypad_entry_if;
  logic        KEY_VALID;
  logic [3:0]  KEY_CODE;
  logic        AUTH_OK;
  logic [3:0]  CARD_ID;
  logic [3:0]  PIN0;
  logic [3:0]  PIN1;
  logic [3:0]  PIN2;
  logic [3:0]  PIN3;
  logic [1:0]  TRANSACTION;
  logic [31:0] AMOUNT;
  logic        OKAY;
  logic        CANCEL;
  logic [1:0]  ENTRY_STATE;
  logic [3:0]  DIGIT_COUNT;
  logic        KEY_ERROR;

  // Keypad/controller side: drives keys and the auth result.
  modport master (
    output KEY_VALID, KEY_CODE, AUTH_OK,
    input  CARD_ID, PIN0, PIN1, PIN2, PIN3, TRANSACTION, AMOUNT,
           OKAY, CANCEL, ENTRY_STATE, DIGIT_COUNT, KEY_ERROR
  );

  // Entry block side.
  modport slave (
    input  KEY_VALID, KEY_CODE, AUTH_OK,
    output CARD_ID, PIN0, PIN1, PIN2, PIN3, TRANSACTION, AMOUNT,
           OKAY, CANCEL, ENTRY_STATE, DIGIT_COUNT, KEY_ERROR
  );
endinterface
`default_nettype wire

// File: rtl/atm_keypad_entry.sv
`default_nettype none
// ============================================================================
//  Module      : atm_keypad_entry
//  Description : Converts single-key strobes into the ATM controller's
//                parallel CARD/PIN/TRANSACTION/AMOUNT inputs with OKAY hold,
//                CANCEL sign-out and inactivity timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module atm_keypad_entry #(
  parameter int OKAY_CYCLES       = 2,
  parameter int TIMEOUT_CYCLES    = 1000,
  parameter int MAX_AMOUNT_DIGITS = 6
) (
  input  wire logic          CLK,
  input  wire logic          RESET,
  atm_keypad_entry_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_CARD = 2'b00,
    ST_PIN  = 2'b01,
    ST_TXN  = 2'b10,
    ST_HOLD = 2'b11
  } state_e;

  localparam int HOLD_W = (OKAY_CYCLES > 1) ? $clog2(OKAY_CYCLES) : 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [HOLD_W-1:0] c_hold_last   = HOLD_W'(OKAY_CYCLES - 1);
  localparam logic [TO_W-1:0]   c_to_last     = TO_W'(TIMEOUT_CYCLES - 1);
  // TXN count includes the code digit, so amount digits are still allowed
  // while the count is at most MAX_AMOUNT_DIGITS.
  localparam logic [3:0]        c_amt_cnt_max = 4'(MAX_AMOUNT_DIGITS);
  localparam logic [3:0] c_key_enter  = 4'hA;
  localparam logic [3:0] c_key_cancel = 4'hB;
  localparam logic [3:0] c_key_clear  = 4'hC;
  localparam logic [1:0] c_txn_bal    = 2'b01;

  state_e            state_q, state_d;
  state_e            ret_q, ret_d;          // state that entered HOLD
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        card_buf_q, card_buf_d;
  logic [3:0][3:0]   pin_buf_q, pin_buf_d;
  logic [1:0]        txn_buf_q, txn_buf_d;
  logic [31:0]       amt_buf_q, amt_buf_d;
  logic [3:0]        card_id_q, card_id_d;
  logic [3:0][3:0]   pin_out_q, pin_out_d;
  logic [1:0]        txn_out_q, txn_out_d;
  logic [31:0]       amount_q, amount_d;
  logic              okay_q, okay_d;
  logic              cancel_q, cancel_d;
  logic              key_error_q, key_error_d;

  logic w_is_digit, w_is_enter, w_is_cancel, w_is_clear;
  logic w_accept, w_cancel_req;

  assign w_is_digit  = (bus.KEY_CODE <= 4'd9);
  assign w_is_enter  = (bus.KEY_CODE == c_key_enter);
  assign w_is_cancel = (bus.KEY_CODE == c_key_cancel);
  assign w_is_clear  = (bus.KEY_CODE == c_key_clear);

  // Next-state, buffer and output-register computation for every key/state.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    hold_cnt_d  = hold_cnt_q;
    cnt_d       = cnt_q;
    card_buf_d  = card_buf_q;
    pin_buf_d   = pin_buf_q;
    txn_buf_d   = txn_buf_q;
    amt_buf_d   = amt_buf_q;
    card_id_d   = card_id_q;
    pin_out_d   = pin_out_q;
    txn_out_d   = txn_out_q;
    amount_d    = amount_q;
    okay_d      = okay_q;
    cancel_d    = 1'b0;
    key_error_d = 1'b0;
    w_accept     = 1'b0;
    w_cancel_req = 1'b0;

    case (state_q)
      ST_CARD: begin
        if (bus.KEY_VALID) begin
          if (w_is_digit) begin
            if (cnt_q == 4'd0) begin
              card_buf_d = bus.KEY_CODE;
              cnt_d      = 4'd1;
            end else key_error_d = 1'b1;
          end else if (w_is_enter) begin
            if (cnt_q == 4'd1) begin
              card_id_d = card_buf_q;
              w_accept  = 1'b1;
            end else key_error_d = 1'b1;
          end else if (w_is_cancel) w_cancel_req = 1'b1;
          else if (w_is_clear) cnt_d = 4'd0;
          else key_error_d = 1'b1;
        end
      end
      ST_PIN: begin
        if (bus.KEY_VALID) begin
          if (w_is_digit) begin
            if (cnt_q < 4'd4) begin
              pin_buf_d[cnt_q[1:0]] = bus.KEY_CODE;
              cnt_d = cnt_q + 4'd1;
            end else key_error_d = 1'b1;
          end else if (w_is_enter) begin
            if (cnt_q == 4'd4) begin
              pin_out_d = pin_buf_q;
              w_accept  = 1'b1;
            end else key_error_d = 1'b1;
          end else if (w_is_cancel) w_cancel_req = 1'b1;
          else if (w_is_clear) cnt_d = 4'd0;
          else key_error_d = 1'b1;
        end else if (to_cnt_q == c_to_last) begin
          w_cancel_req = 1'b1;
        end
      end
      ST_TXN: begin
        if (bus.KEY_VALID) begin
          if (w_is_digit) begin
            if (cnt_q == 4'd0) begin
              if (bus.KEY_CODE <= 4'd2) begin
                txn_buf_d = bus.KEY_CODE[1:0];
                amt_buf_d = 32'd0;
                cnt_d     = 4'd1;
              end else key_error_d = 1'b1;
            end else if (txn_buf_q == c_txn_bal) begin
              key_error_d = 1'b1;           // balance takes no amount
            end else if (cnt_q <= c_amt_cnt_max) begin
              amt_buf_d = amt_buf_q * 32'd10 + 32'(bus.KEY_CODE);
              cnt_d     = cnt_q + 4'd1;
            end else key_error_d = 1'b1;
          end else if (w_is_enter) begin
            if ((cnt_q != 4'd0) && ((txn_buf_q == c_txn_bal) || (cnt_q >= 4'd2))) begin
              txn_out_d = txn_buf_q;
              amount_d  = (txn_buf_q == c_txn_bal) ? 32'd0 : amt_buf_q;
              w_accept  = 1'b1;
            end else key_error_d = 1'b1;
          end else if (w_is_cancel) w_cancel_req = 1'b1;
          else if (w_is_clear) begin
            cnt_d     = 4'd0;
            amt_buf_d = 32'd0;
          end else key_error_d = 1'b1;
        end else if (to_cnt_q == c_to_last) begin
          w_cancel_req = 1'b1;
        end
      end
      default: begin  // ST_HOLD
        if (bus.KEY_VALID && w_is_cancel) begin
          w_cancel_req = 1'b1;
        end else begin
          if (bus.KEY_VALID) key_error_d = 1'b1;
          if (hold_cnt_q == c_hold_last) begin
            okay_d     = 1'b0;
            hold_cnt_d = '0;
            case (ret_q)
              ST_PIN:  state_d = bus.AUTH_OK ? ST_TXN : ST_PIN;
              ST_TXN:  state_d = ST_TXN;
              default: state_d = ST_PIN;
            endcase
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
    endcase

    // Accepted ENTER: outputs were loaded above; start the OKAY hold.
    if (w_accept) begin
      state_d    = ST_HOLD;
      ret_d      = state_q;
      okay_d     = 1'b1;
      hold_cnt_d = '0;
      cnt_d      = 4'd0;
      amt_buf_d  = 32'd0;
    end

    // Key or timeout sign-out; output registers keep their values.
    if (w_cancel_req) begin
      state_d    = ST_CARD;
      okay_d     = 1'b0;
      hold_cnt_d = '0;
      cnt_d      = 4'd0;
      amt_buf_d  = 32'd0;
      cancel_d   = 1'b1;
    end

    // Idle counter runs only while staying in PIN/TXN with no key.
    if (((state_q == ST_PIN) || (state_q == ST_TXN)) && (state_d == state_q) && !bus.KEY_VALID)
      to_cnt_d = to_cnt_q + 1'b1;
    else
      to_cnt_d = '0;
  end

  // State and register update with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_CARD;
      ret_q       <= ST_CARD;
      hold_cnt_q  <= '0;
      to_cnt_q    <= '0;
      cnt_q       <= '0;
      card_buf_q  <= '0;
      pin_buf_q   <= '0;
      txn_buf_q   <= '0;
      amt_buf_q   <= '0;
      card_id_q   <= '0;
      pin_out_q   <= '0;
      txn_out_q   <= '0;
      amount_q    <= '0;
      okay_q      <= 1'b0;
      cancel_q    <= 1'b0;
      key_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      hold_cnt_q  <= hold_cnt_d;
      to_cnt_q    <= to_cnt_d;
      cnt_q       <= cnt_d;
      card_buf_q  <= card_buf_d;
      pin_buf_q   <= pin_buf_d;
      txn_buf_q   <= txn_buf_d;
      amt_buf_q   <= amt_buf_d;
      card_id_q   <= card_id_d;
      pin_out_q   <= pin_out_d;
      txn_out_q   <= txn_out_d;
      amount_q    <= amount_d;
      okay_q      <= okay_d;
      cancel_q    <= cancel_d;
      key_error_q <= key_error_d;
    end
  end

  assign bus.CARD_ID     = card_id_q;
  assign bus.PIN0        = pin_out_q[0];
  assign bus.PIN1        = pin_out_q[1];
  assign bus.PIN2        = pin_out_q[2];
  assign bus.PIN3        = pin_out_q[3];
  assign bus.TRANSACTION = txn_out_q;
  assign bus.AMOUNT      = amount_q;
  assign bus.OKAY        = okay_q;
  assign bus.CANCEL      = cancel_q;
  assign bus.ENTRY_STATE = state_q;
  assign bus.DIGIT_COUNT = cnt_q;
  assign bus.KEY_ERROR   = key_error_q;

endmodule
`default_nettype wire
